// File: rtl/mealy_fsm_pkg.sv
// Shared layout and mode constants for the table-driven Mealy automaton.
// Table entries are packed {next, out} with the output field in the low bits.
package mealy_fsm_pkg;

  localparam logic OUT_COMB = 1'b0;
  localparam logic OUT_REG  = 1'b1;

  localparam int DEF_STATE_W = 2;
  localparam int DEF_IN_W    = 2;
  localparam int DEF_OUT_W   = 2;

  localparam int ENTRY_W  = DEF_STATE_W + DEF_OUT_W;
  localparam int OUT_LSB  = 0;
  localparam int NEXT_LSB = DEF_OUT_W;

  function automatic int entry_w(int sw, int ow);
    return sw + ow;
  endfunction

  function automatic int next_lsb(int ow);
    return OUT_LSB + ow;
  endfunction

endpackage

// File: rtl/mealy_fsm_table.sv
// Register-based transition table: one write port, one async read port.
// Reads see the pre-edge contents, so a same-edge write is read-before-write.
module mealy_fsm_table
  import mealy_fsm_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [STATE_W+IN_W-1:0] waddr,
  input  logic [STATE_W-1:0]      wnext,
  input  logic [OUT_W-1:0]        wout,
  input  logic [STATE_W+IN_W-1:0] raddr,
  output logic [STATE_W-1:0]      rnext,
  output logic [OUT_W-1:0]        rout
);

  localparam int EW   = entry_w(STATE_W, OUT_W);
  localparam int NXT  = next_lsb(OUT_W);
  localparam int NUM  = 2 ** (STATE_W + IN_W);

  logic [EW-1:0] mem [NUM];

  // Default entry {s, x} self-loops on s with zero output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM; i++) begin
        mem[i] <= {STATE_W'(i >> IN_W), OUT_W'(0)};
      end
    end else if (we) begin
      mem[waddr] <= {wnext, wout};
    end
  end

  assign rnext = mem[raddr][NXT +: STATE_W];
  assign rout  = mem[raddr][OUT_LSB +: OUT_W];

endmodule

// File: rtl/mealy_fsm_engine.sv
// Table-driven Mealy automaton with step enable and comb/registered output.
// Optional state-change counter on step_count: MEALY_FSM_STEP_COUNTER_EN.
module mealy_fsm_engine
  import mealy_fsm_pkg::*;
#(
  parameter int STATE_W     = DEF_STATE_W,
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int RESET_STATE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IN_W-1:0]         a,
  input  logic                    enable,
  input  logic                    out_reg,
  input  logic                    cfg_we,
  input  logic [STATE_W+IN_W-1:0] cfg_addr,
  input  logic [STATE_W-1:0]      cfg_next,
  input  logic [OUT_W-1:0]        cfg_out,
`ifdef MEALY_FSM_STEP_COUNTER_EN
  output logic [31:0]             step_count,
`endif
  output logic [OUT_W-1:0]        b,
  output logic [STATE_W-1:0]      state
);

  logic [STATE_W-1:0] e_next;
  logic [OUT_W-1:0]   e_out;
  logic [STATE_W-1:0] state_d;
  logic [OUT_W-1:0]   b_q;
  logic [OUT_W-1:0]   b_d;

  mealy_fsm_table #(
    .STATE_W (STATE_W),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wnext (cfg_next),
    .wout  (cfg_out),
    .raddr ({state, a}),
    .rnext (e_next),
    .rout  (e_out)
  );

  always_comb begin
    state_d = state;
    b_d     = b_q;
    if (enable) begin
      state_d = e_next;
      b_d     = e_out;
    end
  end

  // b register loads on every enabled edge so a mode switch shows a fresh value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STATE_W'(RESET_STATE);
      b_q   <= '0;
    end else begin
      state <= state_d;
      b_q   <= b_d;
    end
  end

  assign b = (out_reg == OUT_REG) ? b_q : e_out;

`ifdef MEALY_FSM_STEP_COUNTER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_count <= '0;
    end else if (enable && (e_next != state)) begin
      step_count <= step_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mealy_fsm_engine.sv
// Scoreboard bench for mealy_fsm_engine: directed cycles push expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mealy_fsm_engine;

  logic       clk;
  logic       reset;
  logic [1:0] a;
  logic       enable;
  logic       out_reg;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [1:0] cfg_next;
  logic [1:0] cfg_out;
  logic [1:0] b;
  logic [1:0] state;
`ifdef MEALY_FSM_STEP_COUNTER_EN
  logic [31:0] step_count;
`endif

  typedef struct {
    string       nm;
    logic [1:0]  st;
    logic [1:0]  bv;
    logic [31:0] cnt;
    bit          chk_b;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;

  mealy_fsm_engine dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .enable     (enable),
    .out_reg    (out_reg),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_next   (cfg_next),
    .cfg_out    (cfg_out),
`ifdef MEALY_FSM_STEP_COUNTER_EN
    .step_count (step_count),
`endif
    .b          (b),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".state"}, 32'(state), 32'(e.st));
      if (e.chk_b) chk({e.nm, ".b"}, 32'(b), 32'(e.bv));
`ifdef MEALY_FSM_STEP_COUNTER_EN
      chk({e.nm, ".count"}, step_count, e.cnt);
`endif
    end
  end

  task automatic cyc(string nm, logic rs, logic [1:0] av, logic en,
                     logic orr, logic we, logic [3:0] ad,
                     logic [1:0] nx, logic [1:0] ot,
                     logic [1:0] es, logic [1:0] eb, int ec, bit cb);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rs;
    a        = av;
    enable   = en;
    out_reg  = orr;
    cfg_we   = we;
    cfg_addr = ad;
    cfg_next = nx;
    cfg_out  = ot;
    e.nm    = nm;
    e.st    = es;
    e.bv    = eb;
    e.cnt   = 32'(ec);
    e.chk_b = cb;
    q.push_back(e);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b0;
    a        = '0;
    enable   = 1'b0;
    out_reg  = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_next = '0;
    cfg_out  = '0;

    cyc("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      cyc("dflt", 1, 2'(i), 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    cyc("prog03", 1, 0, 0, 0, 1, 4'd3,  2, 3, 0, 0, 0, 1);
    cyc("prog21", 1, 0, 0, 0, 1, 4'd9,  3, 1, 0, 0, 0, 1);
    cyc("prog30", 1, 0, 0, 0, 1, 4'd12, 3, 0, 0, 0, 0, 1);
    cyc("prog31", 1, 0, 0, 0, 1, 4'd13, 0, 2, 0, 0, 0, 1);

    cyc("comb0", 1, 3, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1);
    cyc("comb1", 1, 1, 1, 0, 0, 0, 0, 0, 2, 1, 1, 1);
    cyc("comb2", 1, 0, 1, 0, 0, 0, 0, 0, 3, 0, 2, 1);
    cyc("comb3", 1, 0, 1, 0, 0, 0, 0, 0, 3, 0, 2, 1);
    cyc("comb4", 1, 1, 1, 0, 0, 0, 0, 0, 3, 2, 2, 1);
    cyc("prep",  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0);

    cyc("reg0", 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1);
    cyc("reg1", 1, 1, 1, 1, 0, 0, 0, 0, 2, 3, 4, 1);
    cyc("reg2", 1, 0, 1, 1, 0, 0, 0, 0, 3, 1, 5, 1);
    cyc("reg3", 1, 0, 1, 1, 0, 0, 0, 0, 3, 0, 5, 1);
    cyc("reg4", 1, 1, 1, 1, 0, 0, 0, 0, 3, 0, 5, 1);
    cyc("to_s2", 1, 3, 1, 1, 0, 0, 0, 0, 0, 2, 6, 1);

    for (int i = 0; i < 5; i++)
      cyc("hold", 1, 1, 0, 1, 0, 0, 0, 0, 2, 3, 7, 1);
    cyc("resume", 1, 1, 1, 1, 0, 0, 0, 0, 2, 3, 7, 1);
    cyc("to_s0", 1, 1, 1, 1, 0, 0, 0, 0, 3, 1, 8, 1);

    cyc("coll",   1, 3, 1, 0, 1, 4'd3, 1, 2, 0, 3, 9, 1);
    cyc("back1",  1, 1, 1, 0, 0, 0, 0, 0, 2, 1, 10, 1);
    cyc("back2",  1, 1, 1, 0, 0, 0, 0, 0, 3, 2, 11, 1);
    cyc("newent", 1, 3, 1, 0, 0, 0, 0, 0, 0, 2, 12, 1);
    cyc("s1wr",   1, 0, 0, 0, 1, 4'd4, 3, 1, 1, 0, 13, 1);
    cyc("to_s3",  1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 13, 1);
    cyc("s3",     1, 3, 0, 1, 0, 0, 0, 0, 3, 1, 14, 1);

    cyc("rstmid",  0, 3, 1, 1, 1, 4'd3, 2, 2, 0, 0, 0, 1);
    cyc("rstcomb", 0, 3, 1, 0, 1, 4'd3, 2, 2, 0, 0, 0, 1);
    cyc("rel",     1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("dflt03",  1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
